// File: rtl/vmem_port_arbiter_if.sv
// vmem_port_arbiter_if
//   Bundles the display read path, the buffered pixel-write request and
//   clear control, and the single-port frame-buffer RAM port of
//   vmem_port_arbiter.
//
//   Handshake: a write transfer happens on a rising clk edge where
//   wr_valid && wr_ready are both high. wr_addr/wr_data must be stable
//   while wr_valid is high. wr_ready depends only on buffer occupancy, never
//   on wr_valid. The display path and clear_req have no handshake. The
//   display path is a plain per-cycle request. clear_req is a one-cycle pulse.
//
//   Modports:
//     slave  - arbiter side (vmem_port_arbiter)
//     master - requester / RAM side (vga_ctrl, writer, RAM, testbench)
interface vmem_port_arbiter_if #(
  parameter int AW = 19,
  parameter int DW = 24
);
  // display read path
  logic          disp_valid;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  // buffered pixel writes
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  // frame clear
  logic          clear_req;
  logic [DW-1:0] clear_color;
  logic          clear_busy;
  // RAM port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  disp_valid, disp_addr,
    output disp_data,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready,
    input  clear_req, clear_color,
    output clear_busy,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output disp_valid, disp_addr,
    input  disp_data,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready,
    output clear_req, clear_color,
    input  clear_busy,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/vmem_port_arbiter.sv
// vmem_port_arbiter
//   Time-shares one single-port synchronous video RAM between the VGA
//   scan-out reads, a buffered pixel-write requester and a full-frame clear
//   engine. Display reads always win the port. A running clear comes next.
//   Buffered writes come last. Display data returns two cycles after the
//   read request and is forced to black outside the active region.
//
// Ports:
//   clk        - sole clock, rising edge
//   resetn     - asynchronous active-low reset
//   bus        - vmem_port_arbiter_if.slave (display, write, clear, RAM port)
//   state_dbg  - current FSM state (0 = IDLE, 1 = CLEAR)
module vmem_port_arbiter #(
  parameter int AW         = 19,
  parameter int DW         = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  vmem_port_arbiter_if.slave   bus,
  output logic                 state_dbg
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_addr_q;
  logic [DW-1:0] clear_color_q;

  // write buffer
  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   count_q;
  logic          full, empty, push, pop;

  logic          clr_grant;
  logic          clr_last;
  logic          rd_d1_q;

  assign full          = (count_q == (PW+1)'(FIFO_DEPTH));
  assign empty         = (count_q == '0);
  // A full buffer refuses a push even when it pops in the same cycle.
  assign push          = bus.wr_valid && !full;
  assign bus.wr_ready  = !full;
  assign bus.clear_busy = (state_q == ST_CLEAR);
  assign state_dbg     = state_q;
  assign clr_last      = (clr_addr_q == {AW{1'b1}});

  // Port arbitration and next state. The RAM port is combinational, so it is
  // held quiet while reset is asserted regardless of the inputs.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    pop           = 1'b0;
    clr_grant     = 1'b0;
    state_d       = state_q;

    if (resetn) begin
      if (bus.disp_valid) begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.disp_addr;
      end else if (state_q == ST_CLEAR) begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = clr_addr_q;
        bus.mem_wdata = clear_color_q;
        clr_grant     = 1'b1;
      end else if (!empty) begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = fifo_addr[rd_ptr_q];
        bus.mem_wdata = fifo_data[rd_ptr_q];
        pop           = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE:  if (bus.clear_req) state_d = ST_CLEAR;
      ST_CLEAR: if (clr_grant && clr_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      clr_addr_q    <= '0;
      clear_color_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && bus.clear_req) begin
        clr_addr_q    <= '0;
        clear_color_q <= bus.clear_color;
      end else if (clr_grant && !clr_last) begin
        // The last address is left in place rather than wrapping to 0.
        clr_addr_q <= clr_addr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_addr[wr_ptr_q] <= bus.wr_addr;
        fifo_data[wr_ptr_q] <= bus.wr_data;
        wr_ptr_q            <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Read return. RAM data arrives one cycle after the request and is
  // registered once more. Cycles that were not display reads output black.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_d1_q       <= 1'b0;
      bus.disp_data <= '0;
    end else begin
      rd_d1_q       <= bus.disp_valid;
      bus.disp_data <= rd_d1_q ? bus.mem_rdata : '0;
    end
  end

endmodule
